// File: rtl/anspwm_pkg.sv
// Shared types and helpers for the ANS-PWM combine stage.
package anspwm_pkg;

  localparam int unsigned DW = 16;

  // Sign-magnitude stage output; sgn=1 means negative.
  typedef struct packed {
    logic          sgn;
    logic [DW-1:0] mag;
  } sm_t;

  // Width of the signed sum of n terms, each DW+1 bits signed.
  function automatic int unsigned sum_width(input int unsigned dw, input int unsigned n);
    return dw + 1 + $clog2(n);
  endfunction

  // Sign-magnitude to two's complement; negative zero maps to zero.
  function automatic logic signed [DW:0] sm_to_signed(input sm_t x);
    logic signed [DW:0] m;
    m = signed'({1'b0, x.mag});
    return x.sgn ? -m : m;
  endfunction

  // Clamp a signed sum into 0 .. 2**pbits-1.
  function automatic logic [15:0] clamp_duty(input logic signed [31:0] s,
                                             input int unsigned pbits);
    logic signed [31:0] maxv;
    maxv = (32'sd1 <<< pbits) - 32'sd1;
    if (s < 32'sd0)       return 16'h0000;
    else if (s > maxv)    return maxv[15:0];
    else                  return s[15:0];
  endfunction

  // True when clamp_duty would alter the sum.
  function automatic logic duty_clamped(input logic signed [31:0] s,
                                        input int unsigned pbits);
    logic signed [31:0] maxv;
    maxv = (32'sd1 <<< pbits) - 32'sd1;
    return (s < 32'sd0) || (s > maxv);
  endfunction

endpackage

// File: rtl/anspwm_combine_pwm_counter.sv
// Free-running PWM counter with double-buffered duty, bypass on wrap and overrun flag.
module anspwm_combine_pwm_counter #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [PWM_BITS-1:0] wr_data,
  output logic [PWM_BITS-1:0] duty,
  output logic                pwm_out,
  output logic                period_start,
  output logic                overrun
);
  import anspwm_pkg::*;

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] pend_q;
  logic                pend_flag_q;
  logic                wrap_c;

  assign wrap_c = (cnt_q == CNT_MAX);

  // Counter, duty load at wrap, pending buffer and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_flag_q  <= 1'b0;
      duty         <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      cnt_q        <= cnt_q + PWM_BITS'(1);
      pwm_out      <= (cnt_q < duty);
      period_start <= (cnt_q == '0);
      overrun      <= wr_en & pend_flag_q & ~wrap_c;
      if (wrap_c) begin
        // A write landing on the wrap edge goes straight to duty.
        if (wr_en) begin
          duty <= wr_data;
        end else if (pend_flag_q) begin
          duty <= pend_q;
        end
        pend_flag_q <= 1'b0;
      end else if (wr_en) begin
        pend_q      <= wr_data;
        pend_flag_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/anspwm_combine_pwm.sv
// ANS-PWM combine stage: sums signed stage corrections, clamps to duty range,
// and drives a double-buffered PWM. Define ANSPWM_SATCNT_EN to build sat_count.
module anspwm_combine_pwm #(
  parameter int unsigned NSTAGES  = 3,
  parameter int unsigned DW       = 16,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [NSTAGES*DW-1:0]  c_mag,
  input  logic [NSTAGES-1:0]     c_sgn,
  output logic [PWM_BITS-1:0]    duty,
  output logic                   pwm_out,
  output logic                   period_start,
  output logic                   sat,
  output logic                   overrun,
  output logic [15:0]            sat_count
);
  import anspwm_pkg::*;

  // Stage magnitudes are zero-extended into the shared sm_t (DW <= package width).
  localparam int unsigned PDW = anspwm_pkg::DW;
  localparam int unsigned TW  = DW + 1;
  localparam int unsigned SW  = sum_width(DW, NSTAGES);

  logic signed [TW-1:0] term_c [NSTAGES];
  logic signed [TW-1:0] term_q [NSTAGES];
  logic                 v1_q;
  logic signed [SW-1:0] sum_c;
  logic [PWM_BITS-1:0]  wr_data_c;
  logic                 clamp_c;

  // Sign-magnitude to signed conversion of every stage.
  always_comb begin
    for (int k = 0; k < NSTAGES; k++) begin
      term_c[k] = TW'(sm_to_signed({c_sgn[k], PDW'(c_mag[k*DW +: DW])}));
    end
  end

  // P1: register converted terms and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      for (int k = 0; k < NSTAGES; k++) term_q[k] <= '0;
    end else begin
      v1_q <= in_valid;
      for (int k = 0; k < NSTAGES; k++) term_q[k] <= term_c[k];
    end
  end

  // P2 combinational: signed sum and clamp into the duty range.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      sum_c = sum_c + SW'(term_q[k]);
    end
    wr_data_c = PWM_BITS'(clamp_duty(32'(sum_c), PWM_BITS));
    clamp_c   = duty_clamped(32'(sum_c), PWM_BITS);
  end

  // P2 register: saturation pulse, aligned with the pending write.
  always_ff @(posedge clk) begin
    if (rst) sat <= 1'b0;
    else     sat <= v1_q & clamp_c;
  end

  anspwm_combine_pwm_counter #(
    .PWM_BITS (PWM_BITS)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (v1_q),
    .wr_data      (wr_data_c),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .overrun      (overrun)
  );

`ifdef ANSPWM_SATCNT_EN
  // Saturating count of sat pulses.
  always_ff @(posedge clk) begin
    if (rst)                            sat_count <= 16'h0000;
    else if (sat && sat_count != 16'hFFFF) sat_count <= sat_count + 16'h0001;
  end
`else
  assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_anspwm_combine_pwm.sv
// Randomised + directed bench for anspwm_combine_pwm against a behavioural model.
module tb_anspwm_combine_pwm;
  localparam int unsigned NST    = 3;
  localparam int unsigned DWT    = 16;
  localparam int unsigned PB     = 8;
  localparam int          PERIOD = 256;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [NST*DWT-1:0] c_mag;
  logic [NST-1:0]     c_sgn;
  logic [PB-1:0]      duty;
  logic               pwm_out;
  logic               period_start;
  logic               sat;
  logic               overrun;
  logic [15:0]        sat_count;

  anspwm_combine_pwm #(.NSTAGES(NST), .DW(DWT), .PWM_BITS(PB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .c_mag(c_mag), .c_sgn(c_sgn),
    .duty(duty), .pwm_out(pwm_out), .period_start(period_start), .sat(sat),
    .overrun(overrun), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int sat_seen = 0;
  int ovr_seen = 0;

  // Behavioural model state: counter position, active/pending duty, pipeline sample.
  int m_cnt = 0, m_duty = 0, m_pend = 0, m_satcnt = 0, m_p1sum = 0;
  int m_wv = 0;
  bit m_flag = 0, m_pwm = 0, m_ps = 0, m_sat = 0, m_ovr = 0, m_p1v = 0, m_wc = 0, m_wrap = 0;

  function automatic int in_sum();
    int s;
    int m;
    s = 0;
    for (int k = 0; k < NST; k++) begin
      m = int'(c_mag[k*DWT +: DWT]);
      s += c_sgn[k] ? -m : m;
    end
    return s;
  endfunction

  // Model: sample accepted at edge N lands in duty buffer at edge N+1.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_duty = 0; m_pend = 0; m_flag = 0; m_pwm = 0; m_ps = 0;
      m_sat = 0; m_ovr = 0; m_satcnt = 0; m_p1v = 0; m_p1sum = 0;
    end else begin
      if (m_p1sum < 0)                begin m_wv = 0;          m_wc = 1; end
      else if (m_p1sum > PERIOD - 1)  begin m_wv = PERIOD - 1; m_wc = 1; end
      else                            begin m_wv = m_p1sum;    m_wc = 0; end
      m_wrap = (m_cnt == PERIOD - 1);
`ifdef ANSPWM_SATCNT_EN
      if (m_sat && m_satcnt != 65535) m_satcnt++;
`endif
      m_pwm = (m_cnt < m_duty);
      m_ps  = (m_cnt == 0);
      m_sat = m_p1v && m_wc;
      m_ovr = m_p1v && m_flag && !m_wrap;
      if (m_wrap) begin
        if (m_p1v)       m_duty = m_wv;
        else if (m_flag) m_duty = m_pend;
        m_flag = 0;
      end else if (m_p1v) begin
        m_pend = m_wv;
        m_flag = 1;
      end
      m_cnt   = (m_cnt + 1) % PERIOD;
      m_p1v   = in_valid;
      m_p1sum = in_sum();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic step();
    @(negedge clk);
    chk("duty",         32'(duty),         32'(m_duty));
    chk("pwm_out",      32'(pwm_out),      32'(m_pwm));
    chk("period_start", 32'(period_start), 32'(m_ps));
    chk("sat",          32'(sat),          32'(m_sat));
    chk("overrun",      32'(overrun),      32'(m_ovr));
    chk("sat_count",    32'(sat_count),    32'(m_satcnt));
    if (sat === 1'b1)     sat_seen++;
    if (overrun === 1'b1) ovr_seen++;
  endtask

  task automatic wait_cnt(input int target);
    int i;
    for (i = 0; i < 600; i++) begin
      if (m_cnt == target) break;
      step();
    end
    if (i == 600) chk("wait_cnt_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input int m0, input bit s0, input int m1, input bit s1,
                      input int m2, input bit s2);
    c_mag = {16'(m2), 16'(m1), 16'(m0)};
    c_sgn = {s2, s1, s0};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Wait for the next period start, then count pwm_out high cycles over one period.
  task automatic run_period(output int highs);
    int i;
    highs = 0;
    for (i = 0; i < 600; i++) begin
      step();
      if (m_ps) break;
    end
    if (i == 600) chk("period_timeout", 32'd1, 32'd0);
    highs = int'(pwm_out);
    for (int j = 1; j < PERIOD; j++) begin
      step();
      highs += int'(pwm_out);
    end
  endtask

  initial begin
    int h;
    rst = 1'b1; in_valid = 1'b0; c_mag = '0; c_sgn = '0;
    repeat (3) step();
    chk("rst_duty",   32'(duty),      32'd0);
    chk("rst_pwm",    32'(pwm_out),   32'd0);
    chk("rst_ps",     32'(period_start), 32'd0);
    chk("rst_satcnt", 32'(sat_count), 32'd0);
    rst = 1'b0;
    step();
    chk("first_ps", 32'(period_start), 32'd1);

    // Normal sum 100 - 5 + 2 = 97.
    wait_cnt(10); sat_seen = 0;
    send(100, 0, 5, 1, 2, 0);
    run_period(h);
    chk("norm_duty", 32'(duty), 32'd97);
    chk("norm_high", 32'(h), 32'd97);
    chk("norm_sat",  32'(sat_seen), 32'd0);

    // Negative sum clamps to 0.
    wait_cnt(10); sat_seen = 0;
    send(10, 0, 20, 1, 0, 0);
    run_period(h);
    chk("neg_duty", 32'(duty), 32'd0);
    chk("neg_high", 32'(h), 32'd0);
    chk("neg_sat",  32'(sat_seen), 32'd1);
`ifdef ANSPWM_SATCNT_EN
    chk("neg_satcnt", 32'(sat_count), 32'd1);
`else
    chk("neg_satcnt", 32'(sat_count), 32'd0);
`endif

    // Large sum clamps to 255.
    wait_cnt(10); sat_seen = 0;
    send(300, 0, 0, 0, 0, 0);
    run_period(h);
    chk("hi_duty", 32'(duty), 32'd255);
    chk("hi_high", 32'(h), 32'd255);
    chk("hi_sat",  32'(sat_seen), 32'd1);

    // Negative zero everywhere is a plain zero.
    wait_cnt(10); sat_seen = 0;
    send(0, 1, 0, 1, 0, 1);
    run_period(h);
    chk("nz_duty", 32'(duty), 32'd0);
    chk("nz_sat",  32'(sat_seen), 32'd0);

    // Write landing on the wrap edge bypasses into duty.
    wait_cnt(254); ovr_seen = 0;
    send(40, 0, 0, 0, 0, 0);
    step();
    chk("byp_duty_now", 32'(duty), 32'd40);
    run_period(h);
    chk("byp_high", 32'(h), 32'd40);
    chk("byp_ovr",  32'(ovr_seen), 32'd0);

    // Two writes in one period: overrun, last value wins.
    wait_cnt(20); ovr_seen = 0;
    send(10, 0, 0, 0, 0, 0);
    wait_cnt(30);
    send(20, 0, 0, 0, 0, 0);
    run_period(h);
    chk("ovr_count", 32'(ovr_seen), 32'd1);
    chk("ovr_duty",  32'(duty), 32'd20);
    chk("ovr_high",  32'(h), 32'd20);

    // Reset mid-period with duty 128.
    wait_cnt(5);
    send(128, 0, 0, 0, 0, 0);
    run_period(h);
    chk("mid_duty_pre", 32'(duty), 32'd128);
    wait_cnt(60);
    rst = 1'b1;
    step();
    chk("mid_duty", 32'(duty), 32'd0);
    chk("mid_pwm",  32'(pwm_out), 32'd0);
    chk("mid_satcnt", 32'(sat_count), 32'd0);
    rst = 1'b0;
    step();
    chk("mid_ps", 32'(period_start), 32'd1);

    // Randomised traffic: sparse then dense writes, mixed magnitudes, rare resets.
    for (int i = 0; i < 4000; i++) begin
      int rate;
      rate = (i < 2000) ? 40 : 3;
      in_valid = ($urandom_range(0, rate - 1) == 0);
      for (int k = 0; k < NST; k++) begin
        if ($urandom_range(0, 9) == 0) c_mag[k*DWT +: DWT] = 16'($urandom);
        else                           c_mag[k*DWT +: DWT] = 16'($urandom_range(0, 200));
      end
      c_sgn = NST'($urandom);
      rst = ($urandom_range(0, 1499) == 0);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
